noc_packet_buffer: RTL
======================

# noc_packet_buffer

- Single-channel NoC flit buffer placed directly downstream of a compute tile's link output (`link_out_*`).
- Accepts flits with a last marker and a valid/ready handshake, stores them in a circular FIFO, and re-emits them on an identical handshake toward the NoC router or test sink.
- Tracks complete packets so that whole-packet release can be enabled.
- Multi-channel tiles instantiate one buffer per channel.

## Interface
Parameters:
- FLIT_WIDTH, 32, flit payload width; matches the configured NoC flit width.
- DEPTH, 16, number of flit entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_flit  in  FLIT_WIDTH  flit from the tile.
- in_last  in  1  marks the final flit of a packet.
- in_valid  in  1  the upstream side presents a flit.
- in_ready  out  1  the buffer can accept a flit this cycle.
- out_flit  out  FLIT_WIDTH  head flit toward the NoC.
- out_last  out  1  last marker of the head flit.
- out_valid  out  1  the head flit is presentable.
- out_ready  in  1  the downstream side accepts the head flit.
- fill_level  out  $clog2(DEPTH)+1  number of stored flits.
- pkt_count  out  $clog2(DEPTH)+1  number of stored flits with the last marker set.

Clocking and reset (already decided): one clock; reset is synchronous and active-high.

## Operation
Storage:
- Memory of DEPTH entries, each FLIT_WIDTH+1 bits (flit plus last).
- Write pointer and read pointer, each $clog2(DEPTH) bits; both wrap from DEPTH-1 to 0.
- A count register gives fill_level. Full when fill_level==DEPTH; empty when fill_level==0.

Handshakes:
- Push happens on a cycle with in_valid && in_ready: the memory is written at the write pointer and the write pointer increments.
- Pop happens on a cycle with out_valid && out_ready: the read pointer increments.
- Push and pop in the same cycle leave fill_level unchanged.
- in_ready = !full. It does not depend on out_ready; there is no pop-through-when-full path.
- out_flit and out_last read the memory combinationally at the read pointer (first-word fall-through).
- out_flit and out_last are don't-care while out_valid=0.

Packet counter:
- pkt_count increments on a push with in_last=1.
- pkt_count decrements on a pop with out_last=1.
- When both occur in one cycle, pkt_count is unchanged.
- pkt_count never exceeds fill_level.

Release rule:
- The release rule is selected by the macro described under Configuration.

Protocol:
- Once out_valid is asserted, out_valid and out_flit hold until popped. No flit is dropped, duplicated or reordered.
- Reset mid-packet discards all contents, including partial packets. The upstream side must restart the packet after reset.

## Timing
- Reset values: in_ready=1, out_valid=0, fill_level=0, pkt_count=0, both pointers 0. out_flit and out_last are undefined (memory is not cleared).
- Cut-through latency: a flit pushed at edge N is presented on out_* in the cycle after edge N (one cycle). There is no empty bypass.
- Store-and-forward latency: out_valid rises in the cycle after the edge that pushed the last flit.
- in_ready deasserts in the cycle after the push that fills the buffer.
- in_ready reasserts in the cycle after the first pop from full.
- Sustained throughput is one flit per cycle when the buffer is neither empty nor full.

## Configuration
Macro: NOC_PACKET_BUFFER_STORE_FORWARD_EN.

- **Defined:** out_valid = (pkt_count!=0) || full.
  - A packet is released only after its last flit is stored.
  - The `|| full` term prevents deadlock on packets longer than DEPTH: such packets drain in cut-through fashion while the buffer is full.
  - After the head packet starts draining, out_valid stays asserted until that packet's last flit pops, provided flits are available.
- **Undefined:** out_valid = !empty (pure cut-through).
  - pkt_count is still maintained, for observability only.

## Test plan
- **Reset check:** assert rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, fill_level=0, pkt_count=0, no push recorded.
- **Three-flit packet, out_ready=1:**
  - Send 0xA0, 0xA1, 0xA2, with last on 0xA2, on consecutive cycles.
  - Cut-through: output appears 1 cycle after each push.
  - Store-and-forward: 0xA0 appears 1 cycle after 0xA2 is pushed, followed by 0xA1 and 0xA2 back-to-back, with out_last on 0xA2 only.
- **Fill and wrap, DEPTH=16:**
  - Hold out_ready=0 and push 16 single-flit packets -> in_ready=0 after the 16th, fill_level=16, pkt_count=16.
  - Pop 1 -> in_ready=1 the next cycle.
  - Push 0xFF -> 0xFF is stored in entry 0 after the wrap and emerges last, in order.
- **Simultaneous push/pop at fill_level=5:** in_valid=out_ready=1 for 10 cycles -> fill_level stays 5; output order equals input order.
- **Oversize packet (store-and-forward only):**
  - Send 20 flits with last only on the 20th, with out_ready=1.
  - out_valid asserts once fill_level=16; all 20 flits are delivered in order with no deadlock.
- **Reset mid-packet:**
  - Push 2 of 4 flits, then assert rst for 1 cycle -> fill_level=0, pkt_count=0.
  - A subsequent full packet is delivered with no stale flits.

Source files
------------

// File: rtl/noc_packet_buffer.sv
// noc_packet_buffer: single-channel NoC flit buffer with packet tracking.
// A circular FIFO of DEPTH entries, each holding a flit plus its last marker.
// Stored flits are presented first-word fall-through on the output side.
// The optional store-and-forward release is enabled by defining the macro
// NOC_PACKET_BUFFER_STORE_FORWARD_EN. By default the buffer is pure
// cut-through, and pkt_count is kept for observability only.
module noc_packet_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_WIDTH-1:0]   in_flit,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [FLIT_WIDTH-1:0]   out_flit,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic [$clog2(DEPTH):0]  pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [FLIT_WIDTH:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_pkt_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_push_last;
    logic                w_pop_last;
    logic [FLIT_WIDTH:0] w_head;

    assign w_full      = (r_count == FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];

    // Acceptance never looks at out_ready: there is no pop-through path when full.
    assign in_ready    = !w_full;
    assign out_flit    = w_head[FLIT_WIDTH-1:0];
    assign out_last    = w_head[FLIT_WIDTH];
    assign fill_level  = r_count;
    assign pkt_count   = r_pkt_count;

    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign w_push_last = w_push && in_last;
    assign w_pop_last  = w_pop && out_last;

`ifdef NOC_PACKET_BUFFER_STORE_FORWARD_EN
    // Set once the head packet has started draining. It keeps the packet
    // flowing after the buffer drops below full, which matters for packets
    // longer than DEPTH.
    logic r_draining;

    // Tracks whether the head packet is part-way through leaving the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_draining <= 1'b0;
        end else if (w_pop) begin
            r_draining <= !out_last;
        end
    end

    // A complete packet is present, or the buffer is full, or a packet is already draining.
    assign out_valid = !w_empty && ((r_pkt_count != '0) || w_full || r_draining);
`else
    assign out_valid = !w_empty;
`endif

    // Flit storage: written on push, read combinationally at the read pointer.
    // NOTE: storage has no reset; only the pointers and counters define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_flit};
        end
    end

    // Pointer, fill-level and packet-count bookkeeping.
    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_push_last, w_pop_last})
                2'b10:   r_pkt_count <= r_pkt_count + CW'(1);
                2'b01:   r_pkt_count <= r_pkt_count - CW'(1);
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

endmodule
